// File: rtl/jtag_mem_pkg.sv
// rtl/jtag_mem_pkg.sv - shared types and defaults for the JTAG memory bus master
package jtag_mem_pkg;

  localparam int unsigned AW_DEF   = 32;
  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned STEP_DEF = 4;
  localparam int unsigned ERR_BIT  = DW_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2
  } state_e;

  localparam state_e ST_RESET = ST_IDLE;

endpackage

// File: rtl/jtag_dr_shift.sv
// rtl/jtag_dr_shift.sv - DW+1 bit data DR: parallel capture, LSB-first shift, TDO = SR[0]
module jtag_dr_shift #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          capture_i,
  input  logic          shift_i,
  input  logic          tdi_i,
  input  logic [DW:0]   cap_data_i,
  output logic [DW-1:0] data_o,
  output logic          tdo_o
);

  logic [DW:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (capture_i) begin
      sr_d = cap_data_i;
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[DW:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q[DW-1:0];
  assign tdo_o  = sr_q[0];

endmodule

// File: rtl/jtag_mem_ctrl.sv
// rtl/jtag_mem_ctrl.sv - JTAG-side bus master: address/mode register, pointer, bus FSM, data DR
module jtag_mem_ctrl
  import jtag_mem_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned STEP = STEP_DEF
) (
  input  logic          TCK,
  input  logic          RESET_N,
  input  logic [AW-1:0] ADDR_IN,
  input  logic          WR_IN,
  input  logic          INC_IN,
  input  logic          ADDR_UPD,
  input  logic          SEL,
  input  logic          CAPTURE,
  input  logic          SHIFT,
  input  logic          UPDATE,
  input  logic          TDI,
  output logic          TDO,
  output logic          MEM_REQ,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic          MEM_GNT,
  input  logic          MEM_RVALID,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BUSY,
  output logic          ERR
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, maddr_q, maddr_d;
  logic [DW-1:0] rdbuf_q, rdbuf_d, wdata_q, wdata_d;
  logic          mode_wr_q, mode_wr_d, mode_inc_q, mode_inc_d;
  logic          we_q, we_d, err_q, err_d;
  logic [DW-1:0] sr_data;
  logic          sel_cap, sel_upd, sel_shift, busy;
  logic          rd_addr_trig, wr_trig, rd_inc_trig, any_trig, launch;

  assign sel_cap   = SEL & CAPTURE;
  assign sel_upd   = SEL & UPDATE & ~CAPTURE;
  assign sel_shift = SEL & SHIFT & ~CAPTURE & ~UPDATE;
  assign busy      = (state_q != ST_IDLE);

  // An address update owns the cycle, so it suppresses both data-side triggers.
  assign rd_addr_trig = ADDR_UPD & ~WR_IN;
  assign wr_trig      = sel_upd & mode_wr_q & ~ADDR_UPD;
  assign rd_inc_trig  = sel_cap & ~mode_wr_q & mode_inc_q & ~ADDR_UPD;
  assign any_trig     = rd_addr_trig | wr_trig | rd_inc_trig;
  assign launch       = any_trig & ~busy;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    maddr_d    = maddr_q;
    rdbuf_d    = rdbuf_q;
    wdata_d    = wdata_q;
    mode_wr_d  = mode_wr_q;
    mode_inc_d = mode_inc_q;
    we_d       = we_q;
    // Set beats read-to-clear, so a dropped trigger during CAPTURE stays visible.
    err_d      = (err_q & ~sel_cap) | (busy & any_trig) | (ADDR_UPD & sel_upd);

    if (ADDR_UPD && !(busy && rd_addr_trig)) begin
      ptr_d      = ADDR_IN;
      mode_wr_d  = WR_IN;
      mode_inc_d = INC_IN;
    end else if (rd_inc_trig && !busy) begin
      ptr_d = ptr_q + AW'(STEP);
    end else if (state_q == ST_REQ && MEM_GNT && we_q && mode_inc_q) begin
      ptr_d = ptr_q + AW'(STEP);
    end

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_REQ;
          maddr_d = ptr_d;
          we_d    = wr_trig;
          if (wr_trig) wdata_d = sr_data;
        end
      end
      ST_REQ: begin
        if (MEM_GNT) state_d = we_q ? ST_IDLE : ST_RWAIT;
      end
      ST_RWAIT: begin
        if (MEM_RVALID) begin
          rdbuf_d = MEM_RDATA;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge TCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_RESET;
      ptr_q      <= '0;
      maddr_q    <= '0;
      rdbuf_q    <= '0;
      wdata_q    <= '0;
      mode_wr_q  <= 1'b0;
      mode_inc_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      maddr_q    <= maddr_d;
      rdbuf_q    <= rdbuf_d;
      wdata_q    <= wdata_d;
      mode_wr_q  <= mode_wr_d;
      mode_inc_q <= mode_inc_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  jtag_dr_shift #(.DW(DW)) u_dr (
    .clk_i      (TCK),
    .rst_ni     (RESET_N),
    .capture_i  (sel_cap),
    .shift_i    (sel_shift),
    .tdi_i      (TDI),
    .cap_data_i ({err_q, rdbuf_q}),
    .data_o     (sr_data),
    .tdo_o      (TDO)
  );

  assign MEM_REQ   = (state_q == ST_REQ);
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = maddr_q;
  assign MEM_WDATA = wdata_q;
  assign BUSY      = busy;
  assign ERR       = err_q;

endmodule

// File: tb/tb_jtag_mem_ctrl.sv
// tb/tb_jtag_mem_ctrl.sv - self-checking bench for jtag_mem_ctrl
module tb_jtag_mem_ctrl;

  localparam int AW = 32, DW = 32, STEP = 4;

  logic          TCK = 1'b0;
  logic          RESET_N;
  logic [AW-1:0] ADDR_IN;
  logic          WR_IN, INC_IN, ADDR_UPD, SEL, CAPTURE, SHIFT, UPDATE, TDI;
  logic          TDO, MEM_REQ, MEM_WE, MEM_GNT, MEM_RVALID, BUSY, ERR;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA;

  always #5 TCK = ~TCK;

  jtag_mem_ctrl #(.AW(AW), .DW(DW), .STEP(STEP)) dut (
    .TCK(TCK), .RESET_N(RESET_N), .ADDR_IN(ADDR_IN), .WR_IN(WR_IN), .INC_IN(INC_IN),
    .ADDR_UPD(ADDR_UPD), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
    .TDI(TDI), .TDO(TDO), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_GNT(MEM_GNT), .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .ERR(ERR)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus one outstanding bus transaction.
  logic [31:0] m_ptr, m_rdbuf, op_addr, op_data;
  logic        m_wr, m_inc, m_err, op_active, op_write, op_granted;
  logic [32:0] m_sr;

  task automatic model_reset();
    m_ptr = 0; m_rdbuf = 0; op_addr = 0; op_data = 0; m_wr = 0; m_inc = 0; m_err = 0;
    op_active = 0; op_write = 0; op_granted = 0; m_sr = 0;
  endtask

  task automatic model_step();
    logic sc, su, ss, bz, set_err, o_wr, o_inc, o_err, l_go, l_we;
    logic [31:0] o_ptr, o_rdbuf, l_addr, l_data;
    logic [32:0] o_sr;
    sc = SEL && CAPTURE; su = SEL && UPDATE && !CAPTURE; ss = SEL && SHIFT && !CAPTURE && !UPDATE;
    bz = op_active; o_ptr = m_ptr; o_rdbuf = m_rdbuf; o_wr = m_wr; o_inc = m_inc; o_err = m_err; o_sr = m_sr;
    set_err = 0; l_go = 0; l_we = 0; l_addr = 0; l_data = 0;
    if (op_active && !op_granted && MEM_GNT) begin
      if (op_write) begin op_active = 0; if (o_inc) m_ptr = o_ptr + STEP; end
      else op_granted = 1;
    end else if (op_active && op_granted && MEM_RVALID) begin
      m_rdbuf = MEM_RDATA; op_active = 0;
    end
    if (ADDR_UPD) begin
      if (su) set_err = 1;
      if (!WR_IN && bz) set_err = 1;
      else begin
        m_ptr = ADDR_IN; m_wr = WR_IN; m_inc = INC_IN;
        if (!WR_IN) begin l_go = 1; l_addr = ADDR_IN; end
      end
    end else if (su && o_wr) begin
      if (bz) set_err = 1;
      else begin l_go = 1; l_we = 1; l_addr = o_ptr; l_data = o_sr[31:0]; end
    end else if (sc && !o_wr && o_inc) begin
      if (bz) set_err = 1;
      else begin m_ptr = o_ptr + STEP; l_go = 1; l_addr = m_ptr; end
    end
    if (sc) m_sr = {o_err, o_rdbuf};
    else if (ss) m_sr = {TDI, o_sr[32:1]};
    m_err = (o_err && !sc) || set_err;
    if (l_go) begin
      op_active = 1; op_granted = 0; op_write = l_we; op_addr = l_addr;
      if (l_we) op_data = l_data;
    end
  endtask

  task automatic compare();
    chk("mem_req", MEM_REQ, op_active && !op_granted);
    chk("busy", BUSY, op_active);
    chk("err", ERR, m_err);
    chk("tdo", TDO, m_sr[0]);
    if (op_active && !op_granted) begin
      chk("mem_addr", MEM_ADDR, op_addr);
      chk("mem_we", MEM_WE, op_write);
      if (op_write) chk("mem_wdata", MEM_WDATA, op_data);
    end
  endtask

  // Memory responder and transaction log.
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  txn_t        log_q[$];
  logic [31:0] mem [logic [31:0]];
  int          gnt_fixed = -1, rv_fixed = -1, gnt_wait = 0, req_age = 0, rv_cnt = 0;
  bit          rv_pend = 0;
  logic [31:0] rv_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic env_reset();
    req_age = 0; rv_pend = 0; rv_cnt = 0; gnt_wait = (gnt_fixed >= 0) ? gnt_fixed : 0;
    log_q.delete();
  endtask

  task automatic responder();
    MEM_GNT = 0; MEM_RVALID = 0; MEM_RDATA = $urandom;
    if (rv_pend) begin
      if (rv_cnt <= 1) begin MEM_RVALID = 1; MEM_RDATA = mem_rd(rv_addr); rv_pend = 0; end
      else rv_cnt--;
    end else if ($urandom_range(9) == 0) MEM_RVALID = 1;
    if (MEM_REQ) begin
      if (req_age >= gnt_wait) begin
        MEM_GNT = 1;
        log_q.push_back('{MEM_WE, MEM_ADDR, MEM_WDATA});
        if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
        else begin
          rv_pend = 1; rv_addr = MEM_ADDR;
          rv_cnt = (rv_fixed >= 0) ? rv_fixed : int'($urandom_range(3, 1));
        end
        req_age = 0;
        gnt_wait = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(3));
      end else req_age++;
    end else begin
      req_age = 0;
      if ($urandom_range(9) == 0) MEM_GNT = 1;
    end
  endtask

  task automatic tick();
    responder();
    model_step();
    @(posedge TCK);
    @(negedge TCK);
    compare();
    ADDR_UPD = 0; CAPTURE = 0; UPDATE = 0; SHIFT = 0; TDI = 0;
  endtask

  task automatic shift_in(input logic [32:0] v);
    for (int i = 0; i < 33; i++) begin SEL = 1; SHIFT = 1; TDI = v[i]; tick(); end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!BUSY) break;
      tick();
    end
    chk("idle_timeout", BUSY, 1'b0);
  endtask

  task automatic addr_upd(input logic [31:0] a, input logic wr, input logic inc);
    ADDR_IN = a; WR_IN = wr; INC_IN = inc; ADDR_UPD = 1; tick();
  endtask

  logic [32:0] bits;
  logic [31:0] exp_a [3];
  logic [31:0] exp_d [3];

  initial begin
    RESET_N = 0; ADDR_IN = 0; WR_IN = 0; INC_IN = 0; ADDR_UPD = 0; SEL = 0;
    CAPTURE = 0; SHIFT = 0; UPDATE = 0; TDI = 0; MEM_GNT = 0; MEM_RVALID = 0; MEM_RDATA = 0;
    model_reset(); env_reset();
    repeat (2) @(negedge TCK);
    chk("rst_req", MEM_REQ, 0); chk("rst_busy", BUSY, 0); chk("rst_err", ERR, 0);
    chk("rst_tdo", TDO, 0); chk("rst_addr", MEM_ADDR, 0); chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_we", MEM_WE, 0);
    RESET_N = 1;
    compare();

    // 1: reset while a write is stuck in REQ with ERR set
    gnt_fixed = 1000; gnt_wait = 1000;
    addr_upd(32'h40, 1, 0);
    shift_in({1'b0, 32'h0000_1235});
    SEL = 1; UPDATE = 1; tick();
    SEL = 1; UPDATE = 1; tick();
    chk("t1_pre_req", MEM_REQ, 1); chk("t1_pre_err", ERR, 1); chk("t1_pre_tdo", TDO, 1);
    RESET_N = 0;
    #1;
    chk("t1_req", MEM_REQ, 0); chk("t1_busy", BUSY, 0); chk("t1_tdo", TDO, 0); chk("t1_err", ERR, 0);
    gnt_fixed = 2; rv_fixed = 1;
    model_reset(); env_reset();
    @(negedge TCK);
    RESET_N = 1;
    compare();

    // 2: single read, then capture and shift out
    mem[32'h100] = 32'hCAFEF00D;
    addr_upd(32'h100, 0, 0);
    wait_idle();
    chk("t2_nrd", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("t2_addr", log_q[0].addr, 32'h100); chk("t2_we", log_q[0].we, 0);
    end
    SEL = 1; CAPTURE = 1; tick();
    bits[0] = TDO;
    for (int i = 1; i < 33; i++) begin SEL = 1; SHIFT = 1; tick(); bits[i] = TDO; end
    SEL = 1; SHIFT = 1; tick();
    chk("t2_data", bits[31:0], 32'hCAFEF00D);
    chk("t2_errbit", bits[32], 0);

    // 3: auto-increment block write
    gnt_fixed = -1; rv_fixed = -1;
    addr_upd(32'h200, 1, 1);
    log_q.delete();
    exp_a = '{32'h200, 32'h204, 32'h208};
    exp_d = '{32'h11, 32'h22, 32'h33};
    for (int k = 0; k < 3; k++) begin
      shift_in({1'b0, exp_d[k]});
      SEL = 1; UPDATE = 1; tick();
      wait_idle();
    end
    chk("t3_nwr", log_q.size(), 3);
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      chk("t3_addr", log_q[k].addr, exp_a[k]);
      chk("t3_data", log_q[k].data, exp_d[k]);
      chk("t3_we", log_q[k].we, 1);
    end

    // 4: auto-increment reads wrap at the top of the address space
    log_q.delete();
    addr_upd(32'hFFFF_FFFC, 0, 1);
    wait_idle();
    SEL = 1; CAPTURE = 1; tick(); wait_idle();
    SEL = 1; CAPTURE = 1; tick(); wait_idle();
    chk("t4_nrd", log_q.size(), 3);
    exp_a = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int k = 0; k < 3 && k < log_q.size(); k++) chk("t4_addr", log_q[k].addr, exp_a[k]);
    chk("t4_err", ERR, 0);

    // 5: overrun while the grant is withheld
    gnt_fixed = 1000; gnt_wait = 1000;
    addr_upd(32'h400, 1, 0);
    log_q.delete();
    shift_in({1'b0, 32'hA5A5_0001});
    SEL = 1; UPDATE = 1; tick();
    repeat (2) tick();
    shift_in({1'b0, 32'h5A5A_0002});
    SEL = 1; UPDATE = 1; tick();
    chk("t5_err", ERR, 1); chk("t5_req", MEM_REQ, 1);
    chk("t5_addr", MEM_ADDR, 32'h400); chk("t5_wdata", MEM_WDATA, 32'hA5A5_0001);
    gnt_fixed = 0; gnt_wait = 0;
    wait_idle();
    chk("t5_nwr", log_q.size(), 1);
    if (log_q.size() > 0) chk("t5_data", log_q[0].data, 32'hA5A5_0001);
    SEL = 1; CAPTURE = 1; tick();
    chk("t5_err_clr", ERR, 0);
    for (int i = 0; i < 32; i++) begin SEL = 1; SHIFT = 1; tick(); end
    chk("t5_srbit", TDO, 1);

    // 6: address update collides with data UPDATE
    log_q.delete();
    SEL = 1; UPDATE = 1;
    addr_upd(32'h500, 1, 0);
    chk("t6_err", ERR, 1); chk("t6_busy", BUSY, 0);
    tick();
    chk("t6_nowr", log_q.size(), 0);
    shift_in({1'b0, 32'h0BAD_F00D});
    SEL = 1; UPDATE = 1; tick(); wait_idle();
    chk("t6_nwr", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("t6_addr", log_q[0].addr, 32'h500); chk("t6_data", log_q[0].data, 32'h0BAD_F00D);
    end

    // Random traffic against the model
    gnt_fixed = -1; rv_fixed = -1;
    for (int n = 0; n < 3000; n++) begin
      SEL = ($urandom_range(3) != 0);
      CAPTURE = ($urandom_range(9) == 0);
      UPDATE = ($urandom_range(7) == 0);
      SHIFT = $urandom_range(1);
      TDI = $urandom_range(1);
      if ($urandom_range(39) == 0) begin
        case ($urandom_range(2))
          0: ADDR_IN = 32'hFFFF_FFF8;
          1: ADDR_IN = 32'h0;
          default: ADDR_IN = $urandom & 32'hFFFF_FFFC;
        endcase
        WR_IN = $urandom_range(1); INC_IN = $urandom_range(1); ADDR_UPD = 1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
